// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among requesters.
// Generates the shared write address and halts for good at END_ADDRESS.
module fifo_write_arbiter #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_REQ     = 4,
  parameter int          BURST_LEN   = 4,
  parameter logic [31:0] END_ADDRESS = 32'd2147483640
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_wr_en,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     wr_en,
  input  logic                     ready,
  output logic [31:0]              address,
  output logic                     grant_valid,
  output logic [2:0]               grant_id,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_e;

  state_e      state_q;
  logic        grant_valid_q;
  logic [2:0]  grant_id_q;
  logic [2:0]  last_grant_q;
  logic [7:0]  beat_cnt_q;
  logic [31:0] address_q;
  logic        done_q;

  logic [7:0]  wen_pad;
  logic        req_act;
  logic        acc;
  logic [31:0] addr_inc;
  logic [2:0]  pick_d;
  logic        pick_vld_d;
  int          idx;

  always_comb begin
    wen_pad = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wen_pad[i] = req_wr_en[i];
    end
    req_act  = wen_pad[grant_id_q];
    wr_en    = grant_valid_q & req_act
             & (address_q < END_ADDRESS);
    acc      = wr_en & ready;
    addr_inc = address_q + 32'd1;
  end

  always_comb begin
    out       = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid_q && grant_id_q == 3'(i)) begin
        out          = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = acc;
      end
    end
  end

  // Descending scan so the nearest requester after last_grant wins.
  always_comb begin
    pick_d     = '0;
    pick_vld_d = 1'b0;
    idx        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (wen_pad[idx]) begin
        pick_d     = 3'(idx);
        pick_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= 3'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      address_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          grant_valid_q <= 1'b0;
          if (pick_vld_d && !done_q) begin
            grant_id_q    <= pick_d;
            grant_valid_q <= 1'b1;
            beat_cnt_q    <= '0;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (acc) begin
            address_q  <= addr_inc;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (addr_inc == END_ADDRESS) begin
              state_q       <= DONE;
              done_q        <= 1'b1;
              grant_valid_q <= 1'b0;
              last_grant_q  <= grant_id_q;
            end else if (beat_cnt_q == 8'(BURST_LEN - 1)) begin
              state_q       <= IDLE;
              grant_valid_q <= 1'b0;
              last_grant_q  <= grant_id_q;
            end
          end else if (!req_act) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            last_grant_q  <= grant_id_q;
          end
        end
        DONE: begin
          grant_valid_q <= 1'b0;
          done_q        <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address     = address_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed requester traffic,
// a monitor pops expected beats; a second instance covers the end limit.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_wr_en;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  out;
  logic        wr_en;
  logic        ready;
  logic [31:0] address;
  logic        grant_valid;
  logic [2:0]  grant_id;
  logic        done;

  logic [3:0]  l_req_wr_en;
  logic [31:0] l_req_data;
  logic [3:0]  l_req_ready;
  logic [7:0]  l_out;
  logic        l_wr_en;
  logic        l_ready;
  logic [31:0] l_address;
  logic        l_grant_valid;
  logic [2:0]  l_grant_id;
  logic        l_done;

  fifo_write_arbiter #(
    .WIDTH(8), .NUM_REQ(4), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_wr_en(req_wr_en), .req_data(req_data),
    .req_ready(req_ready), .out(out),
    .wr_en(wr_en), .ready(ready),
    .address(address), .grant_valid(grant_valid),
    .grant_id(grant_id), .done(done)
  );

  fifo_write_arbiter #(
    .WIDTH(8), .NUM_REQ(4), .BURST_LEN(4),
    .END_ADDRESS(32'd6)
  ) dut_lim (
    .clk(clk), .reset(reset),
    .req_wr_en(l_req_wr_en), .req_data(l_req_data),
    .req_ready(l_req_ready), .out(l_out),
    .wr_en(l_wr_en), .ready(l_ready),
    .address(l_address), .grant_valid(l_grant_valid),
    .grant_id(l_grant_id), .done(l_done)
  );

  typedef struct {
    logic [2:0]  id;
    logic [7:0]  d;
    logic [31:0] a;
  } beat_t;

  beat_t exp_q[$];
  beat_t lim_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] mem[4][16];
  int         len[4];
  int         ptr[4];
  logic [3:0] acc_snap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    acc_snap = '0;
    forever begin
      @(negedge clk);
      acc_snap = req_ready;
    end
  end

  // Main-instance monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (wr_en && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra id=%0d data=%h addr=%0d want none",
                   grant_id, out, address);
        end else begin
          e = exp_q.pop_front();
          if (out !== e.d || address !== e.a || grant_id !== e.id ||
              req_ready !== (4'b0001 << e.id)) begin
            errors++;
            $display("FAIL beat got id=%0d d=%h a=%0d rdy=%b want id=%0d d=%h a=%0d",
                     grant_id, out, address, req_ready, e.id, e.d, e.a);
          end
        end
      end
    end
  end

  // Limited-instance monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (l_wr_en && l_ready) begin
        checks++;
        if (lim_q.size() == 0) begin
          errors++;
          $display("FAIL lim_extra id=%0d data=%h addr=%0d want none",
                   l_grant_id, l_out, l_address);
        end else begin
          e = lim_q.pop_front();
          if (l_out !== e.d || l_address !== e.a ||
              l_grant_id !== e.id) begin
            errors++;
            $display("FAIL lim_beat got id=%0d d=%h a=%0d want id=%0d d=%h a=%0d",
                     l_grant_id, l_out, l_address, e.id, e.d, e.a);
          end
        end
      end
    end
  end

  function automatic void push(int id, int d, int a);
    beat_t b;
    b.id = 3'(id);
    b.d  = 8'(d);
    b.a  = 32'(a);
    exp_q.push_back(b);
  endfunction

  function automatic void lpush(int id, int d, int a);
    beat_t b;
    b.id = 3'(id);
    b.d  = 8'(d);
    b.a  = 32'(a);
    lim_q.push_back(b);
  endfunction

  task automatic load(int i, int n, int base);
    for (int j = 0; j < n; j++) mem[i][j] = 8'(base + j);
    len[i] = n;
    ptr[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_wr_en[i] = (ptr[i] < len[i]);
      req_data[i*8 +: 8] = (ptr[i] < len[i]) ? mem[i][ptr[i]] : 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc_snap[i]) ptr[i]++;
    drive();
  endtask

  task automatic flush();
    repeat (4) step();
  endtask

  task automatic wait_empty(string n);
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      step();
      b++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d want 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(string n);
    checks++;
    if (wr_en !== 1'b0 || out !== 8'h00 || req_ready !== 4'h0 ||
        grant_valid !== 1'b0 || grant_id !== 3'd0 ||
        address !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got we=%b out=%h rdy=%b gv=%b gid=%0d a=%0d dn=%b want all 0",
               n, wr_en, out, req_ready, grant_valid, grant_id, address, done);
    end
  endtask

  initial begin
    int b;
    reset       = 1'b0;
    ready       = 1'b1;
    req_wr_en   = 4'hF;
    req_data    = 32'hDEADBEEF;
    l_req_wr_en = 4'h0;
    l_req_data  = 32'h0;
    l_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    #12;
    check_reset("reset_init");
    drive();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fairness: all four request, order 0,1,2,3,0
    load(0, 8, 8'h00);
    load(1, 4, 8'h10);
    load(2, 4, 8'h20);
    load(3, 4, 8'h30);
    drive();
    for (int j = 0; j < 4; j++) push(0, j, j);
    for (int j = 0; j < 4; j++) push(1, 8'h10 + j, 4 + j);
    for (int j = 0; j < 4; j++) push(2, 8'h20 + j, 8 + j);
    for (int j = 0; j < 4; j++) push(3, 8'h30 + j, 12 + j);
    for (int j = 0; j < 4; j++) push(0, 4 + j, 16 + j);
    wait_empty("fairness");
    flush();

    reset = 1'b0;
    #1;
    check_reset("reset_pulse");
    step();
    reset = 1'b1;

    // Single requester, two bursts
    load(0, 8, 8'h11);
    drive();
    for (int j = 0; j < 8; j++) push(0, 8'h11 + j, j);
    wait_empty("single");
    flush();

    // Backpressure mid-burst
    load(1, 4, 8'h41);
    drive();
    for (int j = 0; j < 4; j++) push(1, 8'h41 + j, 8 + j);
    b = 0;
    while (exp_q.size() > 2 && b < 50) begin
      step();
      b++;
    end
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || req_ready !== 4'h0 || address !== 32'd10) begin
        errors++;
        $display("FAIL stall got we=%b rdy=%b a=%0d want we=1 rdy=0000 a=10",
                 wr_en, req_ready, address);
      end
      step();
    end
    ready = 1'b1;
    wait_empty("backpressure");
    flush();

    // Early release by req2, then req3, then req1
    load(2, 2, 8'h51);
    load(3, 3, 8'h61);
    load(1, 1, 8'h71);
    drive();
    push(2, 8'h51, 12);
    push(2, 8'h52, 13);
    push(3, 8'h61, 14);
    push(3, 8'h62, 15);
    push(3, 8'h63, 16);
    push(1, 8'h71, 17);
    wait_empty("early_release");
    flush();

    // Reset after beat 2 of a burst
    load(0, 4, 8'h81);
    drive();
    push(0, 8'h81, 18);
    push(0, 8'h82, 19);
    wait_empty("pre_reset");
    #1;
    reset = 1'b0;
    #1;
    check_reset("reset_mid");
    step();
    step();
    reset = 1'b1;
    push(0, 8'h83, 0);
    push(0, 8'h84, 1);
    wait_empty("post_reset");
    flush();

    // End limit on the END_ADDRESS=6 instance
    l_req_data  = {8'h00, 8'h00, 8'hB1, 8'hA0};
    l_req_wr_en = 4'b0011;
    for (int j = 0; j < 4; j++) lpush(0, 8'hA0, j);
    lpush(1, 8'hB1, 4);
    lpush(1, 8'hB1, 5);
    b = 0;
    while (lim_q.size() != 0 && b < 100) begin
      step();
      b++;
    end
    checks++;
    if (lim_q.size() != 0) begin
      errors++;
      $display("FAIL lim_timeout pending=%0d want 0", lim_q.size());
      lim_q.delete();
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (l_done !== 1'b1 || l_wr_en !== 1'b0 ||
          l_grant_valid !== 1'b0 || l_address !== 32'd6) begin
        errors++;
        $display("FAIL lim_done got dn=%b we=%b gv=%b a=%0d want 1 0 0 6",
                 l_done, l_wr_en, l_grant_valid, l_address);
      end
      step();
    end

    checks++;
    if (exp_q.size() != 0 || lim_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d/%0d want 0/0",
               exp_q.size(), lim_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one FIFO/cache write port (out/wr_en/ready/address) among NUM_REQ requesters.
- Each requester presents data plus a write request and receives its own ready.
- The arbiter grants round-robin in bursts of up to BURST_LEN beats.
- It generates the shared sequential write address and stops permanently at END_ADDRESS.

Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- BURST_LEN, 4, maximum accepted beats per grant; legal range 1..255.
- END_ADDRESS, 2147483640, address limit; no writes are issued once address equals this value.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_wr_en  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- req_data  input  NUM_REQ*WIDTH  per-requester data; slice [(i+1)*WIDTH-1:i*WIDTH] belongs to requester i.
- req_ready  output  NUM_REQ  per-requester beat-accept strobe.
- out  output  WIDTH  data to the FIFO.
- wr_en  output  1  write strobe to the FIFO.
- ready  input  1  FIFO can accept this cycle.
- address  output  32  shared write address, incremented per accepted beat.
- grant_valid  output  1  a requester currently holds the grant.
- grant_id  output  3  index of the granted requester.
- done  output  1  END_ADDRESS reached; sticky until reset.

Behaviour:
- Accepted beat (acc) = wr_en & ready.
- Reset values (async assert, active low):
  - state=IDLE, grant_valid=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0, address=0, done=0.
  - Combinational outputs are 0 while reset is asserted.
- Combinational outputs:
  - out = req_data slice of grant_id, valid only when grant_valid; drive 0 otherwise.
  - wr_en = grant_valid & req_wr_en[grant_id] & (address < END_ADDRESS).
  - req_ready[i] = (i==grant_id) & wr_en & ready; all other bits 0.
- State IDLE:
  - grant_valid=0.
  - If any req_wr_en bit is set and done=0: pick the first set bit scanning last_grant+1, last_grant+2, ... (mod NUM_REQ).
  - Register grant_id, set grant_valid=1, beat_cnt=0, go to GRANT.
  - Arbitration latency is one cycle from request to first possible wr_en.
- State GRANT:
  - On acc: address<=address+1, beat_cnt<=beat_cnt+1.
  - Exit to DONE when acc and address+1==END_ADDRESS; this has priority over the other exits.
  - Exit to IDLE when acc and beat_cnt==BURST_LEN-1 (burst complete).
  - Exit to IDLE when req_wr_en[grant_id]==0 (early release, no beat that cycle).
  - On any exit: grant_valid<=0, last_grant<=grant_id.
  - ready low holds state, beat_cnt and address unchanged; data must be held by the requester.
- State DONE:
  - grant_valid=0, wr_en=0, done=1.
  - Requests are ignored; stays in DONE until reset.
- At least one idle cycle separates consecutive grants, including a re-grant of the same requester.
- Non-granted requesters' req_wr_en and req_data are ignored; no beats are dropped or duplicated.
- address wraps nowhere: it saturates at END_ADDRESS by construction.
- Async reset mid-burst returns everything to reset values immediately. The partial burst is abandoned and is not resumed.

Test Plan:
- Single requester: req0 holds req_wr_en with data 0x11..0x18, ready=1, BURST_LEN=4 -> beats 0x11-0x14 at addresses 0-3, one idle cycle, then 0x15-0x18 at addresses 4-7; grant_id=0 throughout.
- Fairness: all 4 requesters requesting continuously -> grant order 0,1,2,3,0; each grant carries 4 beats; address increments by 1 per beat with no gaps in value.
- Backpressure: ready low for 3 cycles mid-burst -> wr_en stays 1, req_ready=0, address and beat_cnt frozen; burst resumes and still totals 4 beats.
- Early release: req2 drops req_wr_en after 2 beats -> the grant ends, last_grant=2, and the next grant goes to req3 if it is requesting.
- End limit: END_ADDRESS=6, two requesters -> exactly 6 beats written, done=1, wr_en=0 forever, even mid-burst.
- Reset mid-burst: assert reset after beat 2 -> all outputs return to reset values asynchronously; after release, the first grant goes to req0 at address 0.
